line_buffer_3x3: RTL and testbench
==================================

LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 28: pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 28: rows per frame, minimum 3.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-004 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port pix_in  in  8  unsigned pixel, row-major stream.
REQ-007 SHALL have port pix_valid  in  1  pix_in is valid.
REQ-008 SHALL have port pix_ready  out  1  block can accept a pixel this cycle.
REQ-009 SHALL have ports out_data_1..out_data_9  out  8 each  3x3 window; 1-3 = oldest row, 7-9 = newest row, left to right.
REQ-010 SHALL have port buf_valid  out  1  window outputs are valid.
REQ-011 SHALL have port row2_cond  out  1  window lies at row >= 2, so all three rows hold real data.
REQ-012 SHALL have port win_ready  in  1  downstream consumes the window.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL treat a pixel as accepted when pix_valid && pix_ready; pix_ready SHALL equal !buf_valid || win_ready, combinationally.
REQ-015 SHALL treat a window as consumed when buf_valid && win_ready.
REQ-016 SHALL, on each accept, perform the following updates.
- Shift the 3x3 tap array one column left.
- Load the new right column as {line1[col], line0[col], pix_in} into out_data_3/6/9.
- Write line1[col] <= line0[col] and line0[col] <= pix_in.
REQ-017 SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1), both advanced on accept.
- col wraps to 0 at IMG_W-1, and row increments at that point.
- row wraps to 0 at IMG_H-1 with col at IMG_W-1; frame_done SHALL pulse on the next cycle.
REQ-018 SHALL set buf_valid to 1 in the cycle after an accept at col >= 2 (1-cycle latency), and row2_cond to (row >= 2) for that pixel.
REQ-019 SHALL, after an accept at col < 2, leave buf_valid at 0 (or drive it to 0 if it was set by a simultaneous consume); no partial windows are emitted.
REQ-020 SHALL hold all window outputs and row2_cond stable while buf_valid && !win_ready.
REQ-021 SHALL, on a simultaneous consume and accept, load the new window in the same cycle with no bubble.
REQ-022 SHALL, on a consume without accept, clear buf_valid on the next cycle.
REQ-023 SHALL NOT clear line memories between frames; row2_cond gates stale rows.
REQ-024 SHALL implement the line memories as two IMG_W x 8 arrays, each with one read and one write per accept.

Reset
REQ-025 SHALL, when rst = 1 at a clk edge, apply the following reset state.
- col = 0, row = 0.
- buf_valid = 0, row2_cond = 0, frame_done = 0.
- out_data_1..9 = 0.
- pix_ready SHALL read 1 after reset.
REQ-026 SHALL leave line memory contents undefined after reset.
REQ-027 SHALL abandon any window in flight when reset is asserted mid-frame; the next accepted pixel is pixel (0,0).

Configuration
REQ-028 SHALL use macro LINE_BUF_WIN_CNT_EN to select an optional window counter.
- Defined: add output win_count  out  16, the count of consumes with row2_cond = 1.
- win_count SHALL reset to 0, clear on the first accept of each frame, and saturate at 16'hFFFF.
- Not defined: the port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-029 SHALL place the following in shared package conv_pkg, used by window_extractor and this block.
- PIX_W = 8.
- WIN_TAPS = 9.
- Default IMG_W and IMG_H.
REQ-030 SHALL use one sub-module, line_mem (single-port-write, single-read array, IMG_W x PIX_W), instantiated twice.

Verification
REQ-031 SHALL cover reset.
- Stimulus: assert rst for 2 cycles with pix_valid = 0.
- Response: all out_data = 0, buf_valid = 0, frame_done = 0, pix_ready = 1.
REQ-032 SHALL cover a basic frame.
- Stimulus: IMG_W = IMG_H = 4, pixels 0..15, win_ready = 1.
- Response: exactly 8 windows, 4 of them with row2_cond = 1.
- The first row2_cond window follows pixel 10 with out_data_1..9 = 0,1,2,4,5,6,8,9,10.
REQ-033 SHALL cover backpressure.
- Stimulus: hold win_ready = 0 for 5 cycles while buf_valid = 1.
- Response: pix_ready = 0 and outputs stable throughout; the window sequence is identical to the scenario in REQ-032.
REQ-034 SHALL cover back-to-back frames.
- Stimulus: two consecutive 4x4 frames.
- Response: frame_done pulses once after each pixel 15.
- Second frame: rows 0-1 windows have row2_cond = 0, and the first row2_cond = 1 window = 0,1,2,4,5,6,8,9,10.
REQ-035 SHALL cover reset mid-frame.
- Stimulus: rst after 7 pixels, then a full 4x4 frame.
- Response: output identical to the scenario in REQ-032.
REQ-036 SHALL cover the optional counter.
- Stimulus: LINE_BUF_WIN_CNT_EN defined, one 4x4 frame.
- Response: win_count = 4 afterwards, and 1 after the first row2_cond = 1 window of the next frame.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared pixel/window constants for the convolution front end.
package conv_pkg;
  localparam int PIX_W     = 8;
  localparam int WIN_TAPS  = 9;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
endpackage

// File: rtl/line_mem.sv
// line_mem: one-row pixel store, one synchronous write and one combinational read.
module line_mem
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3: streams a 3x3 sliding window over a row-major pixel stream.
// Define LINE_BUF_WIN_CNT_EN to add the win_count output (full-window consume count).
module line_buffer_3x3
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] out_data_1,
  output logic [PIX_W-1:0] out_data_2,
  output logic [PIX_W-1:0] out_data_3,
  output logic [PIX_W-1:0] out_data_4,
  output logic [PIX_W-1:0] out_data_5,
  output logic [PIX_W-1:0] out_data_6,
  output logic [PIX_W-1:0] out_data_7,
  output logic [PIX_W-1:0] out_data_8,
  output logic [PIX_W-1:0] out_data_9,
  output logic             buf_valid,
  output logic             row2_cond,
  input  logic             win_ready,
  output logic             frame_done
`ifdef LINE_BUF_WIN_CNT_EN
  ,
  output logic [15:0]      win_count
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] taps_q [WIN_TAPS];
  logic [PIX_W-1:0] taps_d [WIN_TAPS];
  logic             buf_valid_q, buf_valid_d;
  logic             row2_cond_q, row2_cond_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] l0_rd, l1_rd;
  logic             accept, consume, last_col, last_row, win_col;
  assign pix_ready = !buf_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign consume   = buf_valid_q && win_ready;
  assign last_col  = col_q == COL_LAST;
  assign last_row  = row_q == ROW_LAST;
  assign win_col   = col_q >= CW'(2);
  // line0 holds the previous row, line1 the row before it
  line_mem #(.DEPTH(IMG_W), .AW(CW)) u_line0 (
    .clk  (clk),
    .we   (accept),
    .waddr(col_q),
    .wdata(pix_in),
    .raddr(col_q),
    .rdata(l0_rd)
  );
  line_mem #(.DEPTH(IMG_W), .AW(CW)) u_line1 (
    .clk  (clk),
    .we   (accept),
    .waddr(col_q),
    .wdata(l0_rd),
    .raddr(col_q),
    .rdata(l1_rd)
  );
  always_comb begin
    taps_d = taps_q;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        taps_d[3*i]   = taps_q[3*i+1];
        taps_d[3*i+1] = taps_q[3*i+2];
      end
      taps_d[2] = l1_rd;
      taps_d[5] = l0_rd;
      taps_d[8] = pix_in;
    end
    col_d        = accept ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d        = accept && last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    buf_valid_d  = accept ? win_col : (consume ? 1'b0 : buf_valid_q);
    row2_cond_d  = accept && win_col ? (row_q >= RW'(2)) : row2_cond_q;
    frame_done_d = accept && last_col && last_row;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      buf_valid_q  <= 1'b0;
      row2_cond_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) taps_q[i] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      buf_valid_q  <= buf_valid_d;
      row2_cond_q  <= row2_cond_d;
      frame_done_q <= frame_done_d;
      taps_q       <= taps_d;
    end
  end
`ifdef LINE_BUF_WIN_CNT_EN
  logic [15:0] win_count_q, win_count_d;
  // a new frame's first pixel restarts the count, even if a window is consumed alongside
  always_comb begin
    win_count_d = (accept && col_q == '0 && row_q == '0) ? '0 :
                  (consume && row2_cond_q && win_count_q != 16'hFFFF) ? win_count_q + 16'd1 :
                  win_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) win_count_q <= '0;
    else     win_count_q <= win_count_d;
  end
  assign win_count = win_count_q;
`endif
  assign buf_valid  = buf_valid_q;
  assign row2_cond  = row2_cond_q;
  assign frame_done = frame_done_q;
  assign out_data_1 = taps_q[0];
  assign out_data_2 = taps_q[1];
  assign out_data_3 = taps_q[2];
  assign out_data_4 = taps_q[3];
  assign out_data_5 = taps_q[4];
  assign out_data_6 = taps_q[5];
  assign out_data_7 = taps_q[6];
  assign out_data_8 = taps_q[7];
  assign out_data_9 = taps_q[8];
endmodule

// File: tb/tb_line_buffer_3x3.sv
// tb_line_buffer_3x3: directed, table-driven bench for line_buffer_3x3 on a 4x4 image.
module tb_line_buffer_3x3;
  typedef struct packed {
    logic [7:0]  p;
    logic        r2;
    logic [8:0]  m;
    logic [71:0] d;
  } vec_t;
  vec_t tbl [8];
  logic clk = 0, rst = 1, pix_valid = 0, win_ready = 1;
  logic [7:0] pix_in = 0;
  logic pix_ready, buf_valid, row2_cond, frame_done;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8, o9;
  logic [71:0] win;
`ifdef LINE_BUF_WIN_CNT_EN
  logic [15:0] win_count;
`endif
  int checks = 0, errors = 0, widx = 0, nwin = 0, nr2 = 0, nfd = 0;
  logic [7:0] last_pix = 0;
  logic fd_exp = 0, hold = 0, prev_r2 = 0;
  logic [71:0] prev_d = 0;
  vec_t e;
  line_buffer_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .out_data_1(o1), .out_data_2(o2), .out_data_3(o3), .out_data_4(o4), .out_data_5(o5),
    .out_data_6(o6), .out_data_7(o7), .out_data_8(o8), .out_data_9(o9),
    .buf_valid(buf_valid), .row2_cond(row2_cond), .win_ready(win_ready), .frame_done(frame_done)
`ifdef LINE_BUF_WIN_CNT_EN
    , .win_count(win_count)
`endif
  );
  assign win = {o1, o2, o3, o4, o5, o6, o7, o8, o9};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("pix_ready", pix_ready, !buf_valid || win_ready);
    chk("frame_done", frame_done, fd_exp);
    if (hold) begin
      chk("hold_data", win, prev_d);
      chk("hold_r2", row2_cond, prev_r2);
      chk("hold_bv", buf_valid, 1'b1);
    end
    hold = buf_valid && !win_ready && !rst;
    prev_d = win;
    prev_r2 = row2_cond;
    if (rst) widx = 0;
    else if (buf_valid && win_ready) begin
      e = tbl[widx % 8];
      chk($sformatf("win%0d_pix", widx), last_pix, e.p);
      chk($sformatf("win%0d_r2", widx), row2_cond, e.r2);
      for (int k = 0; k < 9; k++)
        if (e.m[8-k]) chk($sformatf("win%0d_tap%0d", widx, k + 1), win[(8-k)*8 +: 8], e.d[(8-k)*8 +: 8]);
      nwin++;
      if (row2_cond) nr2++;
      widx++;
    end
    fd_exp = pix_valid && pix_ready && !rst && pix_in == 8'd15;
    if (pix_valid && pix_ready && !rst) last_pix = pix_in;
    if (frame_done) nfd++;
  end
  task automatic send(input int p);
    int n;
    logic ok;
    n = 0;
    ok = 0;
    pix_in = 8'(p);
    pix_valid = 1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pixel %0d not accepted within 100 cycles", p);
    end
  endtask
  task automatic send_range(input int first, input int last);
    for (int p = first; p <= last; p++) send(p);
    pix_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bp();
    int n;
    n = 0;
    while (!(buf_valid && widx % 8 == 4) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL bp_timeout row2 window not seen within 500 cycles");
    end
    win_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", pix_ready, 1'b0);
      chk("bp_valid", buf_valid, 1'b1);
      @(posedge clk);
      #2;
    end
    win_ready = 1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n0, r0, f0;
    tbl[0] = '{8'd2,  1'b0, 9'b000000111, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2}};
    tbl[1] = '{8'd3,  1'b0, 9'b000000111, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3}};
    tbl[2] = '{8'd6,  1'b0, 9'b000111111, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6}};
    tbl[3] = '{8'd7,  1'b0, 9'b000111111, {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7}};
    tbl[4] = '{8'd10, 1'b1, 9'b111111111, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}};
    tbl[5] = '{8'd11, 1'b1, 9'b111111111, {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};
    tbl[6] = '{8'd14, 1'b1, 9'b111111111, {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}};
    tbl[7] = '{8'd15, 1'b1, 9'b111111111, {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_win", win, 72'd0);
    chk("rst_bv", buf_valid, 1'b0);
    chk("rst_r2", row2_cond, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ready", pix_ready, 1'b1);
`ifdef LINE_BUF_WIN_CNT_EN
    chk("rst_wcnt", win_count, 16'd0);
`endif
    @(posedge clk);
    #1;
    rst = 0;
    send_range(0, 15);
    idle(4);
    chk("basic_nwin", nwin, 8);
    chk("basic_nr2", nr2, 4);
    chk("basic_nfd", nfd, 1);
    fork
      send_range(0, 15);
      bp();
    join
    idle(4);
    chk("bp_nwin", nwin, 16);
    chk("bp_nr2", nr2, 8);
    chk("bp_nfd", nfd, 2);
    send(0);
    for (int p = 1; p < 32; p++) send(p % 16);
    pix_valid = 0;
    idle(4);
    chk("b2b_nwin", nwin, 32);
    chk("b2b_nr2", nr2, 16);
    chk("b2b_nfd", nfd, 4);
    send_range(0, 6);
    rst = 1;
    idle(1);
    rst = 0;
    n0 = nwin;
    r0 = nr2;
    f0 = nfd;
    chk("midrst_bv", buf_valid, 1'b0);
    send_range(0, 15);
    idle(4);
    chk("midrst_nwin", nwin - n0, 8);
    chk("midrst_nr2", nr2 - r0, 4);
    chk("midrst_nfd", nfd - f0, 1);
`ifdef LINE_BUF_WIN_CNT_EN
    chk("wcnt_frame", win_count, 16'd4);
    send_range(0, 10);
    idle(3);
    chk("wcnt_next", win_count, 16'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
